// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer: captures nine 18-bit results and streams them LSB-first as 27 bytes under valid/ready.
module matrix_result_serializer #(
  parameter int N_ELEM = 9,
  parameter int ELEM_W = 18,
  parameter int BYTE_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_ELEM*ELEM_W-1:0]   c_flat,
  output logic [BYTE_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [3:0]                 elem_idx,
  output logic                       busy,
  output logic                       done
);
  localparam int BYTES_PER_ELEM = (ELEM_W + BYTE_W - 1) / BYTE_W;
  localparam int PAD_W = BYTES_PER_ELEM * BYTE_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  logic [0:0]                state;
  logic [N_ELEM*ELEM_W-1:0]  shadow;
  logic [1:0]                byte_cnt;
  logic [ELEM_W-1:0]         cur;
  logic [PAD_W-1:0]          cur_pad;
  logic                      last_byte;
  assign cur       = shadow[ELEM_W*elem_idx +: ELEM_W];
  assign cur_pad   = {{(PAD_W-ELEM_W){1'b0}}, cur};
  assign last_byte = (elem_idx == 4'(N_ELEM-1)) && (byte_cnt == 2'(BYTES_PER_ELEM-1));
  assign busy      = (state == SEND);
  assign out_valid = busy;
  assign out_last  = busy && last_byte;
  // Gate the byte so the bus reads zero whenever nothing is being offered.
  assign out_data  = busy ? cur_pad[BYTE_W*byte_cnt +: BYTE_W] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      byte_cnt <= '0;
      elem_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state    <= SEND;
          shadow   <= c_flat;
          byte_cnt <= '0;
          elem_idx <= '0;
        end
      end else if (out_ready) begin
        if (last_byte) begin
          state    <= IDLE;
          done     <= 1'b1;
          byte_cnt <= '0;
          elem_idx <= '0;
        end else if (byte_cnt == 2'(BYTES_PER_ELEM-1)) begin
          byte_cnt <= '0;
          elem_idx <= elem_idx + 4'd1;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_result_serializer.sv
// tb_matrix_result_serializer: frame-level model plus directed scenarios for the result serializer.
module tb_matrix_result_serializer;
  logic         clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [161:0] c_flat = '0;
  logic [7:0]   out_data;
  logic         out_valid, out_last, busy, done;
  logic [3:0]   elem_idx;
  int n_chk = 0, n_fail = 0, dn_cnt = 0, cyc = 0;
  logic [7:0] rx[$];
  logic [7:0] ref1[$];
  int dn_stamp[$];
  bit mbusy = 0, mdone = 0;
  int mpos = 0;
  logic [17:0] mc[9];

  matrix_result_serializer dut (
    .clk(clk), .rst(rst), .start(start), .c_flat(c_flat),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .elem_idx(elem_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mbyte(int p);
    logic [17:0] e;
    e = mc[p / 3];
    return 8'((e >> (8 * (p % 3))) & 18'hFF);
  endfunction

  // Model: a frame is a position 0..26 into the captured elements.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy = 0; mpos = 0; mdone = 0;
    end else begin
      mdone = 0;
      if (!mbusy) begin
        if (start) begin
          for (int i = 0; i < 9; i++) mc[i] = c_flat[i*18 +: 18];
          mbusy = 1; mpos = 0;
        end
      end else if (out_ready) begin
        if (mpos == 26) begin mbusy = 0; mdone = 1; mpos = 0; end
        else mpos++;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (done) begin dn_cnt++; dn_stamp.push_back(cyc); end
    if (out_valid && out_ready) rx.push_back(out_data);
  end

  always @(negedge clk) begin
    chk("valid", 32'(out_valid), 32'(mbusy));
    chk("busy", 32'(busy), 32'(mbusy));
    chk("data", 32'(out_data), mbusy ? 32'(mbyte(mpos)) : 32'd0);
    chk("last", 32'(out_last), 32'(mbusy && mpos == 26));
    chk("elem", 32'(elem_idx), mbusy ? 32'(mpos / 3) : 32'd0);
    chk("done", 32'(done), 32'(mdone));
  end

  task automatic wait_done(int prev);
    int k;
    for (k = 0; k < 400 && dn_cnt <= prev; k++) tick();
    if (dn_cnt <= prev) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: done not seen, expected count > %0d", prev);
    end
  endtask

  task automatic match_ref(string n);
    int bad = 0;
    if (rx.size() != 27) bad = 1;
    else for (int i = 0; i < 27; i++) if (rx[i] !== ref1[i]) bad++;
    chk(n, 32'(bad), 32'd0);
  endtask

  initial begin
    int d0;
    bit stalled;
    start = 1; out_ready = 1;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_done", 32'(done), 0);
    rst = 0; start = 0;
    repeat (10) tick();
    chk("idle_valid", 32'(out_valid), 0);

    // Scenario: single frame at full throughput
    c_flat[0 +: 18] = 18'h3FFFF;
    c_flat[18 +: 18] = 18'h00001;
    c_flat[144 +: 18] = 18'h2A5C3;
    rx.delete(); d0 = dn_cnt;
    start = 1; tick();
    chk("latency", 32'(out_valid), 1);
    start = 0;
    wait_done(d0);
    repeat (3) tick();
    chk("n_bytes", 32'(rx.size()), 27);
    if (rx.size() == 27) begin
      chk("b0", 32'(rx[0]), 32'hFF); chk("b1", 32'(rx[1]), 32'hFF);
      chk("b2", 32'(rx[2]), 32'h03); chk("b3", 32'(rx[3]), 32'h01);
      chk("b4", 32'(rx[4]), 32'h00); chk("b24", 32'(rx[24]), 32'hC3);
      chk("b25", 32'(rx[25]), 32'hA5); chk("b26", 32'(rx[26]), 32'h02);
    end
    chk("one_done", 32'(dn_cnt - d0), 1);
    ref1 = rx;

    // Scenario: random backpressure with a 5-cycle stall on byte 3
    rx.delete(); d0 = dn_cnt; stalled = 0;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 400 && dn_cnt == d0; k++) begin
      if (!stalled && rx.size() == 3) begin
        out_ready = 0;
        repeat (5) begin
          tick();
          chk("stall_data", 32'(out_data), 32'h01);
          chk("stall_elem", 32'(elem_idx), 1);
        end
        stalled = 1;
      end else out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1;
    chk("bp_done", 32'(dn_cnt - d0), 1);
    match_ref("bp_frame");

    // Scenario: start and new data while busy are ignored
    rx.delete(); d0 = dn_cnt;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 100 && rx.size() < 10; k++) tick();
    c_flat = '1; start = 1; tick(); start = 0;
    wait_done(d0);
    repeat (5) tick();
    chk("ign_done", 32'(dn_cnt - d0), 1);
    match_ref("ign_frame");
    c_flat = '0;
    c_flat[0 +: 18] = 18'h3FFFF; c_flat[18 +: 18] = 18'h00001; c_flat[144 +: 18] = 18'h2A5C3;

    // Scenario: reset mid-frame
    rx.delete(); d0 = dn_cnt;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 100 && rx.size() < 15; k++) tick();
    rst = 1; #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_elem", 32'(elem_idx), 0);
    tick(); rst = 0;
    repeat (5) tick();
    chk("mr_nodone", 32'(dn_cnt - d0), 0);
    rx.delete(); d0 = dn_cnt;
    start = 1; tick(); start = 0;
    wait_done(d0);
    match_ref("mr_frame");

    // Scenario: back-to-back frames with start held high
    repeat (2) tick();
    rx.delete(); dn_stamp.delete(); d0 = dn_cnt;
    start = 1;
    for (int k = 0; k < 300 && dn_cnt < d0 + 3; k++) tick();
    chk("b2b_dones", 32'(dn_cnt - d0), 3);
    chk("b2b_bytes", 32'(rx.size()), 81);
    if (dn_stamp.size() >= 3) begin
      chk("b2b_gap1", 32'(dn_stamp[1] - dn_stamp[0]), 28);
      chk("b2b_gap2", 32'(dn_stamp[2] - dn_stamp[1]), 28);
    end
    if (rx.size() >= 28) chk("b2b_f2b0", 32'(rx[27]), 32'hFF);
    start = 0;
    wait_done(d0 + 3);
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
